// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-source write-back FIFOs with round-robin drain into one register-file write port
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_a_valid,
    output logic              o_a_ready,
    input  logic [4:0]        i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_b_valid,
    output logic              o_b_ready,
    input  logic [4:0]        i_b_addr,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_wen,
    output logic [4:0]        o_rd_addr,
    output logic [DATA_W-1:0] o_rd,
    output logic [31:0]       o_pending,
    output logic              o_idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Index 0 is source A, index 1 is source B.
    logic [4:0]        in_addr  [2];
    logic [DATA_W-1:0] in_data  [2];
    logic [1:0]        in_valid;

    logic [4:0]        addr_mem [2][DEPTH];
    logic [DATA_W-1:0] data_mem [2][DEPTH];
    logic [DEPTH-1:0]  vld      [2];
    logic [PW-1:0]     wp       [2];
    logic [PW-1:0]     rp       [2];
    logic [CW-1:0]     cnt      [2];

    logic [1:0]        full;
    logic [1:0]        nonempty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic              last_b;
    logic [4:0]        head_addr;
    logic [DATA_W-1:0] head_data;

    assign in_addr[0] = i_a_addr;
    assign in_addr[1] = i_b_addr;
    assign in_data[0] = i_a_data;
    assign in_data[1] = i_b_data;
    assign in_valid   = {i_b_valid, i_a_valid};

    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int s = 0; s < 2; s++) begin
            full[s]     = (cnt[s] == CW'(DEPTH));
            nonempty[s] = (cnt[s] != '0);
            // Writes to x0 complete the handshake but are dropped here.
            push[s]     = in_valid[s] && !full[s] && (in_addr[s] != 5'd0);
        end
    end

    always_comb begin
        pop    = '0;
        pop[0] = nonempty[0] && (!nonempty[1] || last_b);
        pop[1] = nonempty[1] && !pop[0];
    end

    always_comb begin
        head_addr = addr_mem[1][rp[1]];
        head_data = data_mem[1][rp[1]];
        if (pop[0]) begin
            head_addr = addr_mem[0][rp[0]];
            head_data = data_mem[0][rp[0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                wp[s]  <= '0;
                rp[s]  <= '0;
                cnt[s] <= '0;
                vld[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (pop[s]) begin
                    vld[s][rp[s]] <= 1'b0;
                    rp[s]         <= rp[s] + 1'b1;
                end
                if (push[s]) begin
                    vld[s][wp[s]] <= 1'b1;
                    wp[s]         <= wp[s] + 1'b1;
                end
                cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
            end
        end
    end

    // Payload storage needs no reset; the valid bits and counts qualify it.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                addr_mem[s][wp[s]] <= in_addr[s];
                data_mem[s][wp[s]] <= in_data[s];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wen     <= 1'b0;
            o_rd_addr <= 5'd0;
            o_rd      <= '0;
            last_b    <= 1'b1;
        end else begin
            o_wen <= |pop;
            if (|pop) begin
                o_rd_addr <= head_addr;
                o_rd      <= head_data;
                last_b    <= pop[1];
            end
        end
    end

    always_comb begin
        o_pending = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[s][i]) begin
                    o_pending[addr_mem[s][i]] = 1'b1;
                end
            end
        end
        if (o_wen) begin
            o_pending[o_rd_addr] = 1'b1;
        end
    end

    assign o_a_ready = !full[0];
    assign o_b_ready = !full[1];
    assign o_idle    = !nonempty[0] && !nonempty[1] && !o_wen;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_a_valid = 1'b0;
    logic          o_a_ready;
    logic [4:0]    i_a_addr = '0;
    logic [DW-1:0] i_a_data = '0;
    logic          i_b_valid = 1'b0;
    logic          o_b_ready;
    logic [4:0]    i_b_addr = '0;
    logic [DW-1:0] i_b_data = '0;
    logic          o_wen;
    logic [4:0]    o_rd_addr;
    logic [DW-1:0] o_rd;
    logic [31:0]   o_pending;
    logic          o_idle;

    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_a_valid (i_a_valid),
        .o_a_ready (o_a_ready),
        .i_a_addr  (i_a_addr),
        .i_a_data  (i_a_data),
        .i_b_valid (i_b_valid),
        .o_b_ready (o_b_ready),
        .i_b_addr  (i_b_addr),
        .i_b_data  (i_b_data),
        .o_wen     (o_wen),
        .o_rd_addr (o_rd_addr),
        .o_rd      (o_rd),
        .o_pending (o_pending),
        .o_idle    (o_idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          qa[$];
    ent_t          qb[$];
    bit            m_last_b = 1'b1;
    logic          exp_wen  = 1'b0;
    logic [4:0]    exp_addr = '0;
    logic [DW-1:0] exp_data = '0;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            wlog_addr[$];
    int            wlog_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        foreach (qa[i]) p[qa[i].addr] = 1'b1;
        foreach (qb[i]) p[qb[i].addr] = 1'b1;
        if (exp_wen) p[exp_addr] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_last_b = 1'b1;
        exp_wen  = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    // Applied once per rising edge, using the inputs that were stable across it.
    task automatic model_edge();
        ent_t e;
        bit   ra = (qa.size() < DEPTH);
        bit   rb = (qb.size() < DEPTH);
        exp_wen = 1'b0;
        if (qa.size() > 0 && (qb.size() == 0 || m_last_b)) begin
            e = qa.pop_front();
            m_last_b = 1'b0;
            exp_wen = 1'b1;
            exp_addr = e.addr;
            exp_data = e.data;
        end else if (qb.size() > 0) begin
            e = qb.pop_front();
            m_last_b = 1'b1;
            exp_wen = 1'b1;
            exp_addr = e.addr;
            exp_data = e.data;
        end
        if (i_a_valid && ra && i_a_addr != 5'd0) qa.push_back({i_a_addr, i_a_data});
        if (i_b_valid && rb && i_b_addr != 5'd0) qb.push_back({i_b_addr, i_b_data});
    endtask

    task automatic check_all(input string tag);
        cyc++;
        chk({tag, "_a_ready"}, o_a_ready, (qa.size() < DEPTH));
        chk({tag, "_b_ready"}, o_b_ready, (qb.size() < DEPTH));
        chk({tag, "_wen"}, o_wen, exp_wen);
        chk({tag, "_rd_addr"}, o_rd_addr, exp_addr);
        chk({tag, "_rd"}, o_rd, exp_data);
        chk({tag, "_pending"}, o_pending, exp_pending());
        chk({tag, "_idle"}, o_idle, (qa.size() == 0 && qb.size() == 0 && !exp_wen));
        if (o_wen) begin
            wlog_addr.push_back(int'(o_rd_addr));
            wlog_cyc.push_back(cyc);
        end
    endtask

    task automatic step(input string tag, input bit av, input logic [4:0] aa, input logic [DW-1:0] ad,
                        input bit bv, input logic [4:0] ba, input logic [DW-1:0] bd);
        i_a_valid = av;
        i_a_addr  = aa;
        i_a_data  = ad;
        i_b_valid = bv;
        i_b_addr  = ba;
        i_b_data  = bd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_step(input string tag);
        step(tag, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    // Reset is raised between clock edges and its effect is checked before the next edge.
    task automatic do_reset(input string tag);
        i_a_valid = 1'b0;
        i_b_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, "_during"});
        @(negedge clk);
        rst = 1'b0;
        check_all({tag, "_after"});
    endtask

    initial begin
        int exp_order[6] = '{1, 4, 2, 5, 3, 6};
        bit seen_full;
        bit found;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("init");
        do_reset("rst0");
        idle_step("post_rst0");

        // Single write to r5
        step("single_push", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        chk("single_pend_n", o_pending[5], 1'b1);
        chk("single_wen_n", o_wen, 1'b0);
        idle_step("single_n1");
        chk("single_wen_n1", o_wen, 1'b1);
        chk("single_addr_n1", o_rd_addr, 5'd5);
        chk("single_data_n1", o_rd, 32'hDEADBEEF);
        chk("single_pend_n1", o_pending[5], 1'b1);
        idle_step("single_n2");
        chk("single_pend_n2", o_pending[5], 1'b0);
        chk("single_idle_n2", o_idle, 1'b1);

        // Contention from a fresh reset: A starts
        do_reset("rst1");
        wlog_addr.delete();
        wlog_cyc.delete();
        for (int i = 0; i < 3; i++)
            step("cont_push", 1'b1, 5'(i + 1), $urandom, 1'b1, 5'(i + 4), $urandom);
        repeat (6) idle_step("cont_drain");
        chk("cont_count", wlog_addr.size(), 6);
        if (wlog_addr.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("cont_order", wlog_addr[i], exp_order[i]);
            chk("cont_back_to_back", wlog_cyc[5] - wlog_cyc[0], 5);
        end

        // x0 discard
        step("x0_push", 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, '0);
        chk("x0_ready", o_a_ready, 1'b1);
        repeat (2) begin
            idle_step("x0_wait");
            chk("x0_wen", o_wen, 1'b0);
            chk("x0_pending", o_pending, 32'd0);
            chk("x0_idle", o_idle, 1'b1);
        end

        // Both sources saturated: B must see backpressure, scoreboard tracks every entry
        seen_full = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step("bp", 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            if (!o_b_ready) seen_full = 1'b1;
        end
        chk("bp_b_full_seen", seen_full, 1'b1);
        repeat (10) idle_step("bp_drain");

        // Random traffic, including x0 addresses
        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
        repeat (12) idle_step("rand_drain");

        // Reset with work in flight
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step("mid_fill", 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            if (qa.size() >= 3 && exp_wen) found = 1'b1;
        end
        chk("mid_state_reached", found, 1'b1);
        do_reset("mid_rst");
        chk("mid_wen", o_wen, 1'b0);
        chk("mid_pending", o_pending, 32'd0);
        repeat (4) begin
            idle_step("mid_post");
            chk("mid_post_wen", o_wen, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
